// File: rtl/vector_cpu_seq.sv
// vector_cpu_seq: multi-cycle vector CPU with NREG registers of LANES x LANE_W
// bits and a private single-port synchronous vector memory.
//
// Instructions are taken over a valid/ready handshake. The ALU handles
// LANES_PER_CYC lanes per cycle, so an ADD/MUL needs NSTEP = LANES/LANES_PER_CYC
// ALU cycles before a write-back cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   instr_valid/ready instruction handshake (ready only in IDLE)
//   opcode            000 LOAD, 001 STORE, 010 ADD, 011 MUL, 100 INIT, 101 SADD*
//   rd, rs1, rs2      register indices
//   mem_address       vector memory address
//   init_value        immediate vector for INIT
//   done, err         one-cycle completion pulse, err = illegal opcode
//   busy              FSM not IDLE
//   reg_flat          register r at [r*VEC_W +: VEC_W]
//
// Build option: define SAT_ADD_EN to enable opcode 101 (per-lane unsigned
// saturating add, writes rd only). Without it 101 is illegal.
module vector_cpu_seq #(
  parameter int unsigned LANE_W        = 32,
  parameter int unsigned LANES         = 16,
  parameter int unsigned NREG          = 4,
  parameter int unsigned ADDR_W        = 9,
  parameter int unsigned LANES_PER_CYC = 4,
  localparam int unsigned VEC_W        = LANES * LANE_W,
  localparam int unsigned RI_W         = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [2:0]               opcode,
  input  logic [RI_W-1:0]          rd,
  input  logic [RI_W-1:0]          rs1,
  input  logic [RI_W-1:0]          rs2,
  input  logic [ADDR_W-1:0]        mem_address,
  input  logic [VEC_W-1:0]         init_value,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  output logic [NREG*VEC_W-1:0]    reg_flat
);

  localparam int unsigned NSTEP   = LANES / LANES_PER_CYC;
  localparam int unsigned STEP_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned SLICE_W = LANES_PER_CYC * LANE_W;
  localparam int unsigned W2      = 2 * LANE_W;

  typedef enum logic [1:0] {S_IDLE, S_MEMRD, S_ALU, S_WB} state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_MUL   = 3'b011,
    OP_INIT  = 3'b100,
    OP_SADD  = 3'b101
  } op_t;

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [2:0]          op_q;
  logic [RI_W-1:0]     rd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [VEC_W-1:0]    a_q;
  logic [VEC_W-1:0]    b_q;
  logic [VEC_W-1:0]    lo_buf;
  logic [VEC_W-1:0]    hi_buf;
  logic [VEC_W-1:0]    regs [NREG];

  logic [VEC_W-1:0]    mem [0:(1<<ADDR_W)-1];
  logic [VEC_W-1:0]    mem_q;
  logic                mem_we;

  int unsigned         base;
  logic [SLICE_W-1:0]  step_lo;
  logic [SLICE_W-1:0]  step_hi;
  logic [LANE_W-1:0]   a_l;
  logic [LANE_W-1:0]   b_l;
  logic [W2-1:0]       res;

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  for (genvar r = 0; r < NREG; r++) begin : g_flat
    assign reg_flat[r*VEC_W +: VEC_W] = regs[r];
  end

  // One ALU slice: lanes base .. base+LANES_PER_CYC-1 of the latched operands.
  always_comb begin
    base    = 32'(step) * LANES_PER_CYC;
    step_lo = '0;
    step_hi = '0;
    a_l     = '0;
    b_l     = '0;
    res     = '0;
    for (int unsigned j = 0; j < LANES_PER_CYC; j++) begin
      a_l = a_q[(base + j) * LANE_W +: LANE_W];
      b_l = b_q[(base + j) * LANE_W +: LANE_W];
      if (op_q == OP_MUL) res = W2'(a_l) * W2'(b_l);
      else                res = W2'(a_l) + W2'(b_l);
`ifdef SAT_ADD_EN
      if (op_q == OP_SADD && res[LANE_W]) res[LANE_W-1:0] = '1;
`endif
      step_lo[j*LANE_W +: LANE_W] = res[LANE_W-1:0];
      step_hi[j*LANE_W +: LANE_W] = res[W2-1:LANE_W];
    end
  end

  // Memory: STORE writes at its accept edge, LOAD reads during MEMRD; the two
  // can never coincide since STORE is only accepted in IDLE.
  assign mem_we = !rst && instr_valid && (state == S_IDLE) && (opcode == OP_STORE);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_address] <= regs[rs1];
    if (state == S_MEMRD) mem_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      step   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      op_q   <= '0;
      rd_q   <= '0;
      addr_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      lo_buf <= '0;
      hi_buf <= '0;
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q   <= opcode;
            rd_q   <= rd;
            addr_q <= mem_address;
            case (opcode)
              OP_INIT: begin
                regs[rd] <= init_value;
                done     <= 1'b1;
              end
              OP_STORE: done <= 1'b1;
              OP_LOAD:  state <= S_MEMRD;
              OP_ADD, OP_MUL
`ifdef SAT_ADD_EN
              , OP_SADD
`endif
              : begin
                a_q   <= regs[rs1];
                b_q   <= regs[rs2];
                step  <= '0;
                state <= S_ALU;
              end
              default: begin
                done <= 1'b1;
                err  <= 1'b1;
              end
            endcase
          end
        end
        S_MEMRD: state <= S_WB;
        S_ALU: begin
          lo_buf[base*LANE_W +: SLICE_W] <= step_lo;
          hi_buf[base*LANE_W +: SLICE_W] <= step_hi;
          if (step == STEP_W'(NSTEP - 1)) begin
            step  <= '0;
            state <= S_WB;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        S_WB: begin
          if (op_q == OP_LOAD) begin
            regs[rd_q] <= mem_q;
          end else begin
            regs[rd_q] <= lo_buf;
`ifdef SAT_ADD_EN
            if (op_q != OP_SADD) regs[rd_q + RI_W'(1)] <= hi_buf;
`else
            regs[rd_q + RI_W'(1)] <= hi_buf;
`endif
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_cpu_seq.sv
// Self-checking bench for vector_cpu_seq: a directed table of instructions with
// constant expectations, hand-written reset/pulse sequences, and randomized
// instructions checked against a per-lane arithmetic model.
module tb_vector_cpu_seq;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned LANES  = 16;
  localparam int unsigned NREG   = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned LPC    = 4;
  localparam int unsigned VEC_W  = LANES * LANE_W;
  localparam int unsigned RI_W   = $clog2(NREG);
  localparam int          NSTEP  = LANES / LPC;

  logic                  clk;
  logic                  rst;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [2:0]            opcode;
  logic [RI_W-1:0]       rd, rs1, rs2;
  logic [ADDR_W-1:0]     mem_address;
  logic [VEC_W-1:0]      init_value;
  logic                  done, err, busy;
  logic [NREG*VEC_W-1:0] reg_flat;

  vector_cpu_seq #(
    .LANE_W(LANE_W), .LANES(LANES), .NREG(NREG), .ADDR_W(ADDR_W), .LANES_PER_CYC(LPC)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .mem_address(mem_address),
    .init_value(init_value), .done(done), .err(err), .busy(busy), .reg_flat(reg_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: whole registers and an address-keyed memory.
  logic [VEC_W-1:0] m_reg [NREG];
  logic [VEC_W-1:0] m_mem [int];

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int r = 0; r < NREG; r++)
      chk_vec($sformatf("%s reg%0d", tag, r), reg_flat[r*VEC_W +: VEC_W], m_reg[r]);
  endtask

  function automatic void model_exec(input logic [2:0] op, input int rdv, input int rs1v,
                                     input int rs2v, input int a, input logic [VEC_W-1:0] iv,
                                     output int lat, output logic e);
    logic [VEC_W-1:0] s1, s2, lo, hi;
    longint unsigned x, y, r, maxv;
    maxv = (64'd1 << LANE_W) - 1;
    s1 = m_reg[rs1v];
    s2 = m_reg[rs2v];
    lo = '0;
    hi = '0;
    lat = 0;
    e = 1'b0;
    case (op)
      3'd0: begin lat = 2; m_reg[rdv] = m_mem[a]; end
      3'd1: m_mem[a] = m_reg[rs1v];
      3'd2, 3'd3: begin
        lat = NSTEP + 1;
        for (int i = 0; i < LANES; i++) begin
          x = 64'(s1[i*LANE_W +: LANE_W]);
          y = 64'(s2[i*LANE_W +: LANE_W]);
          r = (op == 3'd2) ? x + y : x * y;
          lo[i*LANE_W +: LANE_W] = LANE_W'(r & maxv);
          hi[i*LANE_W +: LANE_W] = LANE_W'(r >> LANE_W);
        end
        m_reg[rdv] = lo;
        m_reg[(rdv + 1) % NREG] = hi;
      end
`ifdef SAT_ADD_EN
      3'd5: begin
        lat = NSTEP + 1;
        for (int i = 0; i < LANES; i++) begin
          x = 64'(s1[i*LANE_W +: LANE_W]);
          y = 64'(s2[i*LANE_W +: LANE_W]);
          r = x + y;
          if (r > maxv) r = maxv;
          lo[i*LANE_W +: LANE_W] = LANE_W'(r);
        end
        m_reg[rdv] = lo;
      end
`endif
      3'd4: m_reg[rdv] = iv;
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one instruction (driven on a falling edge), wait for done, and check
  // latency, err, handshake status and all registers against the model.
  task automatic run_instr(input logic [2:0] op, input int rdv, input int rs1v, input int rs2v,
                           input int a, input logic [VEC_W-1:0] iv,
                           output int lat_o, output logic err_o);
    int   n;
    int   exp_lat;
    logic exp_err;
    bit   seen;
    n = 0;
    while (!instr_ready && n < 100) begin @(negedge clk); n++; end
    chk_int("ready_wait", instr_ready, 1);
    opcode      = op;
    rd          = RI_W'(rdv);
    rs1         = RI_W'(rs1v);
    rs2         = RI_W'(rs2v);
    mem_address = ADDR_W'(a);
    init_value  = iv;
    instr_valid = 1'b1;
    model_exec(op, rdv, rs1v, rs2v, a, iv, exp_lat, exp_err);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        chk_int($sformatf("ready_busy_op%0d", op), {instr_ready, busy}, 2'b01);
        n++;
      end
    end
    lat_o = n;
    err_o = err;
    chk_int($sformatf("done_seen_op%0d", op), seen, 1);
    chk_int($sformatf("latency_op%0d", op), n, exp_lat);
    chk_int($sformatf("err_op%0d", op), err, exp_err);
    chk_int("idle_at_done", {instr_ready, busy}, 2'b10);
    chk_regs($sformatf("op%0d", op));
  endtask

  typedef struct {
    logic [2:0]  op;
    int          rdv, rs1v, rs2v, addr;
    logic [31:0] init_lane;
    int          ra;
    logic [31:0] va;
    int          rb;
    logic [31:0] vb;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] op, input int rdv, input int rs1v, input int rs2v,
                              input int addr, input logic [31:0] il, input int ra,
                              input logic [31:0] va, input int rb, input logic [31:0] vb,
                              input logic ee, input int el);
    vec_t v;
    v.op = op; v.rdv = rdv; v.rs1v = rs1v; v.rs2v = rs2v; v.addr = addr;
    v.init_lane = il; v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
    v.exp_err = ee; v.exp_lat = el;
    tbl.push_back(v);
  endfunction

  int               lat;
  logic             e;
  int               dones;
  int               addrs [4];
  logic [VEC_W-1:0] iv;
  int               kind;

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; mem_address = '0; init_value = '0;
    for (int r = 0; r < NREG; r++) m_reg[r] = '0;
    addrs[0] = 0; addrs[1] = 1; addrs[2] = 9'h1FF; addrs[3] = 9'h0A5;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_int("reset_ready", instr_ready, 1);
    chk_int("reset_done", done, 0);
    chk_int("reset_err", err, 0);
    chk_int("reset_busy", busy, 0);
    chk_regs("reset");

    // Directed table: op rd rs1 rs2 addr init | regA valA regB valB err lat
    add(3'd4, 0, 0, 0, 0,     32'd5,        0, 32'd5,        1, 32'd0,        0, 0);
    add(3'd4, 0, 0, 0, 0,     32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2, 32'd0,        0, 0);
    add(3'd4, 1, 0, 0, 0,     32'd2,        1, 32'd2,        0, 32'hFFFFFFFF, 0, 0);
    add(3'd2, 2, 0, 1, 0,     32'd0,        2, 32'd1,        3, 32'd1,        0, NSTEP + 1);
    add(3'd3, 3, 0, 0, 0,     32'd0,        3, 32'd1,        0, 32'hFFFFFFFE, 0, NSTEP + 1);
    add(3'd1, 0, 1, 0, 9'h1FF, 32'd0,       1, 32'd2,        3, 32'd1,        0, 0);
    add(3'd4, 1, 0, 0, 0,     32'd0,        1, 32'd0,        2, 32'd1,        0, 0);
    add(3'd0, 1, 0, 0, 9'h1FF, 32'd0,       1, 32'd2,        0, 32'hFFFFFFFE, 0, 2);
    add(3'd6, 0, 1, 2, 0,     32'd7,        1, 32'd2,        3, 32'd1,        1, 0);
    add(3'd7, 2, 1, 1, 0,     32'd7,        2, 32'd1,        0, 32'hFFFFFFFE, 1, 0);
    add(3'd4, 0, 0, 0, 0,     32'hFFFFFFF0, 0, 32'hFFFFFFF0, 3, 32'd1,        0, 0);
    add(3'd4, 1, 0, 0, 0,     32'h20,       1, 32'h20,       0, 32'hFFFFFFF0, 0, 0);
`ifdef SAT_ADD_EN
    add(3'd5, 2, 0, 1, 0,     32'd0,        2, 32'hFFFFFFFF, 3, 32'd1,        0, NSTEP + 1);
`else
    add(3'd5, 2, 0, 1, 0,     32'd0,        2, 32'd1,        3, 32'd1,        1, 0);
`endif

    for (int k = 0; k < tbl.size(); k++) begin
      run_instr(tbl[k].op, tbl[k].rdv, tbl[k].rs1v, tbl[k].rs2v, tbl[k].addr,
                {LANES{tbl[k].init_lane}}, lat, e);
      chk_int($sformatf("tbl%0d_lat", k), lat, tbl[k].exp_lat);
      chk_int($sformatf("tbl%0d_err", k), e, tbl[k].exp_err);
      chk_vec($sformatf("tbl%0d_regA", k), reg_flat[tbl[k].ra*VEC_W +: VEC_W], {LANES{tbl[k].va}});
      chk_vec($sformatf("tbl%0d_regB", k), reg_flat[tbl[k].rb*VEC_W +: VEC_W], {LANES{tbl[k].vb}});
    end

    // done is a single-cycle pulse when nothing follows.
    run_instr(3'd4, 2, 0, 0, 0, {LANES{32'h1234_5678}}, lat, e);
    @(negedge clk);
    chk_int("done_pulse_width", done, 0);

    // Reset during ALU step 2 of a MUL aborts it entirely.
    opcode = 3'd3; rd = 2'd3; rs1 = 2'd0; rs2 = 2'd1; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < NREG; r++) m_reg[r] = '0;
    dones = 0;
    for (int i = 0; i < NSTEP + 4; i++) begin
      @(negedge clk);
      if (i == 0) chk_int("rst_mid_ready", instr_ready, 1);
      if (done) dones++;
    end
    chk_int("rst_mid_no_done", dones, 0);
    chk_regs("rst_mid");

    // Memory survives reset.
    run_instr(3'd0, 1, 0, 0, 9'h1FF, '0, lat, e);
    chk_vec("mem_after_rst", reg_flat[1*VEC_W +: VEC_W], {LANES{32'd2}});

    // Randomized phase: seed registers and all used addresses first.
    for (int r = 0; r < NREG; r++) begin
      for (int i = 0; i < LANES; i++) iv[i*LANE_W +: LANE_W] = $urandom;
      run_instr(3'd4, r, 0, 0, 0, iv, lat, e);
    end
    for (int k = 0; k < 4; k++) run_instr(3'd1, 0, k % NREG, 0, addrs[k], '0, lat, e);

    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < LANES; i++) begin
        kind = $urandom_range(0, 3);
        iv[i*LANE_W +: LANE_W] = (kind == 0) ? 32'd0 : (kind == 1) ? 32'hFFFFFFFF : $urandom;
      end
      run_instr(3'($urandom_range(0, 7)), $urandom_range(0, NREG - 1),
                $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                addrs[$urandom_range(0, 3)], iv, lat, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_cpu_seq.md
Name: vector_cpu_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle 4x512-bit vector CPU. It holds NREG vector registers of LANES x LANE_W bits and a private synchronous vector memory. Instructions are accepted over a valid/ready handshake and executed by a small FSM. The ALU processes LANES_PER_CYC lanes per cycle, so wide multipliers are time-shared. All registers are exported flat for observation.

Parameters:
LANE_W, 32, bits per lane (unsigned)
LANES, 16, lanes per vector; VEC_W = LANES*LANE_W
NREG, 4, number of vector registers (power of two, >=2); RI_W = log2(NREG)
ADDR_W, 9, memory address width; depth 2**ADDR_W vectors
LANES_PER_CYC, 4, lanes computed per ALU cycle; must divide LANES; NSTEP = LANES/LANES_PER_CYC

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction
opcode  in  3  000 LOAD, 001 STORE, 010 ADD, 011 MUL, 100 INIT, others illegal
rd  in  RI_W  destination register (LOAD/INIT/ADD/MUL)
rs1  in  RI_W  source 1 (ADD/MUL) / store source (STORE)
rs2  in  RI_W  source 2 (ADD/MUL)
mem_address  in  ADDR_W  memory vector address
init_value  in  VEC_W  immediate vector for INIT
done  out  1  one-cycle completion pulse
err  out  1  valid with done: 1 = illegal opcode, no state changed
busy  out  1  FSM not IDLE
reg_flat  out  NREG*VEC_W  register r at bits [r*VEC_W +: VEC_W]

Behaviour:
- Reset: all registers 0, FSM IDLE, instr_ready=1, done=0, err=0, busy=0, lane counter 0. Memory contents not reset.
- Handshake: accept when instr_valid && instr_ready at a rising edge. All operand fields are captured at accept. instr_ready = (state==IDLE). No instruction is accepted while busy.
- States: IDLE, MEMRD, ALU, WB.
  - IDLE --accept INIT--> stays IDLE: rd <= init_value at the accept edge; done=1 next cycle.
  - IDLE --accept STORE--> stays IDLE: mem[addr] <= reg[rs1] at the accept edge; done next cycle.
  - IDLE --LOAD--> MEMRD (memory read issued) --> WB: rd <= mem data --> IDLE; done in the first IDLE cycle. Total latency 2 cycles.
  - IDLE --ADD/MUL--> ALU for NSTEP cycles (counter 0..NSTEP-1, wraps to 0) --> WB commits --> IDLE; done follows. Total latency NSTEP+1 cycles.
  - Illegal opcode: stays IDLE; done=1, err=1 next cycle; no register or memory write.
- Latency reference: done rises in the cycle after the edge on which the architectural write occurred. The new value is visible on reg_flat in the same cycle as done.
- Back-to-back: a new instruction may be accepted in the done cycle.
- ALU width rule: per lane i, res_i = a_i + b_i (ADD, carry kept) or a_i * b_i (MUL). res_i is 2*LANE_W bits, unsigned, zero-extended.
  - Low halves form vector L; high halves form vector H.
  - At WB: reg[rd] <= L and reg[(rd+1) mod NREG] <= H. Both writes occur on the same edge.
- Operand snapshot: sources are latched at accept and results are buffered until WB. rd==rs1, rd==rs2, or rd+1 wrapping onto a source all read the pre-instruction values.
- Memory: single port, synchronous read with 1-cycle latency, write-first not required because read and write never coincide.
- Reset mid-operation: aborts the instruction, no WB, no done pulse, state as reset.

Optional Feature:
SAT_ADD_EN: when defined, opcode 101 = SADD. It runs per-lane unsigned saturating add over NSTEP ALU cycles. Only reg[rd] is written; each lane is clamped to 2**LANE_W-1 on overflow, and rd+1 is untouched. Latency is NSTEP+1, err=0. When not defined, 101 is illegal (done+err, no writes).

Test Plan:
- Reset then INIT rd=0 value all lanes 5 -> done 1 cycle later; reg_flat reg0 lanes = 5, other regs 0, err=0.
- INIT r0 lanes=0xFFFFFFFF, INIT r1 lanes=2, ADD rd=2 rs1=0 rs2=1 -> done after 5 cycles (defaults); r2 lanes=0x00000001, r3 lanes=0x00000001.
- MUL rd=3 rs1=0 rs2=0 with r0 lanes=0xFFFFFFFF -> r3 lanes=0x00000001, r0 (wrap 3+1) lanes=0xFFFFFFFE, committed on the same edge.
- STORE rs1=1 addr=0x1FF, INIT r1 zeros, LOAD rd=1 addr=0x1FF -> r1 lanes=2 after LOAD done (2-cycle latency); instr_ready low during MEMRD.
- Opcode 110 -> done=1, err=1, no reg change. Assert rst during ALU step 2 of a MUL -> no done, all regs 0, instr_ready=1 next cycle.
- With SAT_ADD_EN: SADD r0=0xFFFFFFF0 + r1=0x20 -> rd lanes=0xFFFFFFFF, rd+1 unchanged. Without SAT_ADD_EN: same opcode -> err=1.
